// File: rtl/msg_pkg.sv
// Shared constants for the scrolling message display: message ROM,
// blank character and scroller state encoding.
package msg_pkg;

    localparam int MSG_LEN = 16;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // "HELLO  CHIP ICE." with index 0 first
    localparam logic [7:0] MSG_ROM [0:MSG_LEN-1] = '{
        8'h48, 8'h45, 8'h4C, 8'h4C,
        8'h4F, 8'h20, 8'h20, 8'h43,
        8'h48, 8'h49, 8'h50, 8'h20,
        8'h49, 8'h43, 8'h45, 8'h2E
    };

    typedef enum logic [1:0] {
        IDLE,
        SCROLL,
        HOLD
    } state_e;

endpackage

// File: rtl/tick_divider.sv
// Free-running divider producing a one-cycle tick every CLK_HZ/SCROLL_HZ
// cycles; clear parks the count at zero.
module tick_divider #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCROLL_HZ = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int DIV = CLK_HZ / SCROLL_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/message_scroller.sv
// Scrolls a window of the message ROM across the HEX digits, pausing
// for a number of scroll ticks each time the window wraps to the start.
module message_scroller
    import msg_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int SCROLL_HZ  = 2,
    parameter int NUM_DIGITS = 6,
    parameter int HOLD_TICKS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    dir,
    output logic [NUM_DIGITS*8-1:0] ascii_digits,
    output logic [3:0]              head_idx,
    output logic                    wrap_pulse,
    output logic                    holding
);

    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST =
        HW'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);

    state_e                  state_q, state_d;
    logic [3:0]              head_q, head_d;
    logic [HW-1:0]           hold_q, hold_d;
    logic                    wrap_q, wrap_d;
    logic [NUM_DIGITS*8-1:0] ascii_q, ascii_d;
    logic                    tick;
    logic                    div_clear;

    function automatic logic [NUM_DIGITS*8-1:0] window(input logic [3:0] h);
        logic [NUM_DIGITS*8-1:0] w;
        w = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w[8*k +: 8] = MSG_ROM[h + 4'(NUM_DIGITS - 1 - k)];
        end
        return w;
    endfunction

    // Dropping enable clears the divider on the same edge as the IDLE move
    assign div_clear = !enable || (state_q == IDLE);

    tick_divider #(
        .CLK_HZ    (CLK_HZ),
        .SCROLL_HZ (SCROLL_HZ)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .clear (div_clear),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        hold_d  = hold_q;
        wrap_d  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            head_d  = '0;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = SCROLL;
                    head_d  = '0;
                    hold_d  = '0;
                end
                SCROLL: begin
                    if (tick) begin
                        head_d = dir ? head_q + 4'd15 : head_q + 4'd1;
                        if (head_d == 4'd0) begin
                            wrap_d  = 1'b1;
                            state_d = HOLD;
                            hold_d  = '0;
                        end
                    end
                end
                HOLD: begin
                    if (HOLD_TICKS == 0) begin
                        state_d = SCROLL;
                    end else if (tick) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = SCROLL;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + HW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    head_d  = '0;
                    hold_d  = '0;
                end
            endcase
        end
        ascii_d = (state_d == IDLE) ? {NUM_DIGITS{ASCII_SPACE}}
                                    : window(head_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            head_q  <= '0;
            hold_q  <= '0;
            wrap_q  <= 1'b0;
            ascii_q <= {NUM_DIGITS{ASCII_SPACE}};
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            hold_q  <= hold_d;
            wrap_q  <= wrap_d;
            ascii_q <= ascii_d;
        end
    end

    assign ascii_digits = ascii_q;
    assign head_idx     = head_q;
    assign wrap_pulse   = wrap_q;
    assign holding      = (state_q == HOLD);

endmodule

// File: tb/tb_message_scroller.sv
// Bench for message_scroller: directed table, corner sequences and a
// random run checked against a cycle-level behavioural model.
module tb_message_scroller;

    localparam int CLK_HZ = 8;
    localparam int SCR_HZ = 2;
    localparam int DIV    = CLK_HZ / SCR_HZ;
    localparam int HOLD_T = 2;
    localparam int ND     = 6;
    localparam logic [47:0] SPACES = 48'h202020202020;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        dir;
    logic [47:0] ascii_digits;
    logic [3:0]  head_idx;
    logic        wrap_pulse;
    logic        holding;

    int n_cmp;
    int n_bad;

    // behavioural model state: mode 0 idle, 1 scroll, 2 hold
    int m_mode;
    int m_head;
    int m_phase;
    int m_holdleft;
    bit m_wrap;

    typedef struct {
        bit          en;
        bit          d;
        logic [3:0]  head;
        logic [47:0] ascii;
        bit          wrap;
        bit          hold;
    } vec_t;

    vec_t tbl [6];

    message_scroller #(
        .CLK_HZ     (CLK_HZ),
        .SCROLL_HZ  (SCR_HZ),
        .NUM_DIGITS (ND),
        .HOLD_TICKS (HOLD_T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .dir          (dir),
        .ascii_digits (ascii_digits),
        .head_idx     (head_idx),
        .wrap_pulse   (wrap_pulse),
        .holding      (holding)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [47:0] win(input int h);
        string       msg;
        logic [47:0] w;
        msg = "HELLO  CHIP ICE.";
        w = '0;
        for (int k = 0; k < ND; k++) begin
            w[8*k +: 8] = msg.getc((h + ND - 1 - k) % 16);
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_head = 0;
        m_phase = 0;
        m_holdleft = 0;
        m_wrap = 0;
    endtask

    task automatic model_step(input bit en, input bit d);
        bit tk;
        m_wrap = 0;
        if (!en) begin
            model_reset();
            return;
        end
        tk = (m_mode != 0) && (m_phase == DIV - 1);
        m_phase = (m_mode == 0) ? 0 : (m_phase + 1) % DIV;
        case (m_mode)
            0: m_mode = 1;
            1: if (tk) begin
                m_head = d ? (m_head + 15) % 16 : (m_head + 1) % 16;
                if (m_head == 0) begin
                    m_wrap = 1;
                    m_mode = 2;
                    m_holdleft = HOLD_T;
                end
            end
            default: if (tk) begin
                m_holdleft--;
                if (m_holdleft == 0) m_mode = 1;
            end
        endcase
    endtask

    task automatic check_model(input string tag);
        check({tag, ".ascii"}, 64'(ascii_digits),
              64'((m_mode == 0) ? SPACES : win(m_head)));
        check({tag, ".head"}, 64'(head_idx), 64'(m_head));
        check({tag, ".wrap"}, 64'(wrap_pulse), 64'(m_wrap));
        check({tag, ".hold"}, 64'(holding), 64'(m_mode == 2));
    endtask

    // apply inputs, clock one edge, advance model, sample 1 unit later
    task automatic step(input bit en, input bit d);
        enable = en;
        dir = d;
        @(posedge clk);
        model_step(en, d);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int hcnt;
        int wcnt;
        bit seen;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        enable = 1'b0;
        dir = 1'b0;
        model_reset();

        // async reset before any clock edge
        #1 reset = 1'b1;
        #1;
        check("rst.ascii", 64'(ascii_digits), 64'(SPACES));
        check("rst.head", 64'(head_idx), 64'd0);
        check("rst.hold", 64'(holding), 64'd0);
        check("rst.wrap", 64'(wrap_pulse), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        tbl[0] = '{1, 0, 4'd0, 48'h48454C4C4F20, 0, 0};
        tbl[1] = '{1, 0, 4'd0, 48'h48454C4C4F20, 0, 0};
        tbl[2] = '{1, 0, 4'd0, 48'h48454C4C4F20, 0, 0};
        tbl[3] = '{1, 1, 4'd0, 48'h48454C4C4F20, 0, 0};
        tbl[4] = '{1, 0, 4'd1, 48'h454C4C4F2020, 0, 0};
        tbl[5] = '{0, 0, 4'd0, SPACES, 0, 0};
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].en, tbl[i].d);
            check($sformatf("tbl%0d.ascii", i), 64'(ascii_digits),
                  64'(tbl[i].ascii));
            check($sformatf("tbl%0d.head", i), 64'(head_idx),
                  64'(tbl[i].head));
            check($sformatf("tbl%0d.wrap", i), 64'(wrap_pulse),
                  64'(tbl[i].wrap));
            check($sformatf("tbl%0d.hold", i), 64'(holding),
                  64'(tbl[i].hold));
        end

        // full wrap, hold length and resume
        step(1, 0);
        check_model("wr.start");
        seen = 0;
        wcnt = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step(1, 0);
            check_model("wr.run");
            if (wrap_pulse) wcnt++;
            seen = m_wrap;
        end
        check("wr.reached", 64'(seen), 64'd1);
        check("wr.head0", 64'(head_idx), 64'd0);
        check("wr.pulses", 64'(wcnt), 64'd1);
        hcnt = holding ? 1 : 0;
        for (int i = 0; i < 20 && holding; i++) begin
            step(1, 0);
            check_model("wr.hold");
            if (holding) hcnt++;
        end
        check("wr.holdlen", 64'(hcnt), 64'(DIV * HOLD_T));
        for (int i = 0; i < DIV; i++) begin
            step(1, 0);
            check_model("wr.resume");
        end
        check("wr.head1", 64'(head_idx), 64'd1);

        // reverse scroll from head 0
        step(0, 0);
        check_model("rev.idle");
        step(1, 1);
        for (int i = 0; i < DIV; i++) begin
            step(1, 1);
            check_model("rev.run");
        end
        check("rev.head", 64'(head_idx), 64'd15);
        check("rev.ascii", 64'(ascii_digits), 64'h2E48454C4C4F);
        check("rev.wrap", 64'(wrap_pulse), 64'd0);

        // drop enable on a tick cycle at head 5
        step(0, 0);
        step(1, 0);
        for (int i = 0; i < 5 * DIV; i++) step(1, 0);
        check("dis.head5", 64'(head_idx), 64'd5);
        for (int i = 0; i < DIV - 1; i++) step(1, 0);
        step(0, 0);
        check("dis.ascii", 64'(ascii_digits), 64'(SPACES));
        check("dis.head", 64'(head_idx), 64'd0);
        step(1, 0);
        check("dis.restart", 64'(ascii_digits), 64'h48454C4C4F20);
        for (int i = 0; i < DIV - 1; i++) step(1, 0);
        check("dis.notick", 64'(head_idx), 64'd0);
        step(1, 0);
        check("dis.tick", 64'(head_idx), 64'd1);

        // async reset in the middle of HOLD
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step(1, 0);
            seen = (m_mode == 2);
        end
        check("mh.reached", 64'(holding), 64'd1);
        step(1, 0);
        step(1, 0);
        #2 reset = 1'b1;
        #1;
        check("mh.hold", 64'(holding), 64'd0);
        check("mh.ascii", 64'(ascii_digits), 64'(SPACES));
        check("mh.head", 64'(head_idx), 64'd0);
        do_reset();
        step(1, 0);
        check("mh.restart", 64'(ascii_digits), 64'h48454C4C4F20);
        check_model("mh.model");

        // randomized run against the model
        dir = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit en;
            bit d;
            en = ($urandom_range(0, 99) < 97);
            d = ($urandom_range(0, 9) == 0) ? ~dir : dir;
            step(en, d);
            check_model("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/message_scroller.md
Name: message_scroller

Overview:
ASCII character source that feeds the six per-digit ASCII-to-seven-segment decoders on the HEX0..HEX5 displays. Holds a fixed 16-character message ROM and presents a NUM_DIGITS-wide window of it. The window scrolls by one character per scroll tick, wraps around the message, and holds for a configurable pause at each wrap. Its outputs are raw ASCII bytes; segment encoding stays downstream in the decoders.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz.
SCROLL_HZ, 2, scroll ticks per second; DIV = CLK_HZ/SCROLL_HZ, must be >= 2.
NUM_DIGITS, 6, number of displayed characters.
HOLD_TICKS, 4, scroll ticks spent frozen after each wrap; 0 means no hold.

Ports:
clk  input  1  system clock, single clock domain.
reset  input  1  asynchronous, active-high reset.
enable  input  1  level; 1 = run the display, 0 = blank and rewind.
dir  input  1  0 = scroll left (head increments), 1 = scroll right (head decrements); sampled only on a tick.
ascii_digits  output  NUM_DIGITS*8  registered window; bits [8k+7:8k] drive HEXk (k=0 is rightmost).
head_idx  output  4  message index shown on the leftmost digit.
wrap_pulse  output  1  one-cycle pulse when head_idx becomes 0 by scrolling.
holding  output  1  1 while in HOLD.

Behaviour:
- Reset (async, takes effect immediately, no clock edge needed):
  - state = IDLE, head = 0, divider = 0.
  - ascii_digits = all 0x20, wrap_pulse = 0, holding = 0.
- Message ROM, MSG_LEN = 16, index 0..15: "HELLO  CHIP ICE." Every character is one the decoders support.
- Window mapping: HEXk shows msg[(head + NUM_DIGITS-1-k) mod MSG_LEN], so the leftmost digit shows msg[head].
- Tick divider:
  - Counts 0..DIV-1 while state is SCROLL or HOLD.
  - tick = 1 for the single cycle where count == DIV-1; the count then returns to 0.
  - Cleared to 0 whenever the state is IDLE.
- State IDLE:
  - Outputs all spaces, head = 0.
  - enable = 1 moves to SCROLL on the next edge; ascii_digits shows the head = 0 window from that same edge.
- State SCROLL, on tick:
  - dir = 0: head <= (head+1) mod 16.
  - dir = 1: head <= (head+15) mod 16.
  - If the new head == 0: wrap_pulse = 1 for exactly one cycle, then go to HOLD.
- State HOLD:
  - holding = 1; head and ascii_digits stay frozen.
  - Returns to SCROLL after HOLD_TICKS ticks; with HOLD_TICKS = 0 it returns on the next cycle.
- ascii_digits and head_idx update on the same edge, so the output is consistent with head_idx at all times.
- Width rules:
  - Index arithmetic is 4-bit modulo 16; wrap-around is implicit.
  - The hold counter is sized $clog2(HOLD_TICKS+1).
- enable = 0 in any state:
  - Go to IDLE on the next edge: spaces out, head = 0, divider and hold counter cleared, wrap_pulse = 0.
  - enable = 0 takes priority over a coincident tick or wrap.
- A dir change mid-tick-period has no effect until the next tick.
- Reset mid-HOLD or mid-SCROLL returns to the reset values immediately.

Decomposition:
- Package msg_pkg:
  - MSG_LEN = 16.
  - Message ROM constant (array of 8-bit ASCII).
  - ASCII_SPACE = 8'h20.
  - State enum {IDLE, SCROLL, HOLD}.
- Sub-module tick_divider (params CLK_HZ, SCROLL_HZ; ports clk, reset, clear, tick). It is reused by other timed display blocks.

Test Plan:
All scenarios use CLK_HZ=8, SCROLL_HZ=2 (DIV=4), HOLD_TICKS=2, NUM_DIGITS=6.
1. Assert reset with no clock -> ascii_digits = 0x202020202020 immediately; head_idx = 0; holding = 0.
2. enable=1, dir=0 -> one edge later HEX5..HEX0 = 48 45 4C 4C 4F 20 ("HELLO "). After 4 more cycles head_idx = 1 and HEX5..HEX0 = 45 4C 4C 4F 20 20.
3. Run 16 ticks -> wrap_pulse high exactly one cycle as head_idx becomes 0; holding = 1 for 8 cycles with outputs frozen; head_idx = 1 on the following tick.
4. From head 0 with dir=1 -> next tick head_idx = 15 and HEX5..HEX0 = 2E 48 45 4C 4C 4F; no wrap_pulse.
5. Drop enable at head_idx = 5 on the same cycle as a tick -> next edge all 0x20 and head_idx = 0, with no advance. Re-enable -> "HELLO " again, and the first tick comes 4 cycles later.
6. Assert reset asynchronously mid-HOLD -> holding = 0 and all spaces before the next edge. After release with enable=1 -> normal start as in scenario 2.
